mem_arbiter: RTL and testbench

Two-requester memory arbiter that shares the core's single memory port between the instruction-fetch unit (IFU) and the load/store path (LSU). It sits between the IFU/LSU request interfaces and the memory interface, alongside the IFU/IDU/EXU stages under `top`. It accepts one transaction at a time, latches its payload, drives it to memory with a valid/ready handshake, and routes the response back to the owner.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the core's single memory port between the IFU and the LSU, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; by default the LSU has fixed priority over the IFU.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t state;
  state_t state_nxt;
  owner_t owner;
  logic   grant_ifu;
  logic   grant_lsu;
  logic   accept;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;

  // On a tie the requester that did not win the previous accept goes first.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (ifu_req_valid && lsu_req_valid) begin
      grant_lsu = (last_owner == OWN_IFU);
      grant_ifu = (last_owner == OWN_LSU);
    end else begin
      grant_ifu = ifu_req_valid;
      grant_lsu = lsu_req_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_IFU;
    end else if (accept) begin
      last_owner <= grant_lsu ? OWN_LSU : OWN_IFU;
    end
  end
`else
  always_comb begin
    grant_lsu = lsu_req_valid;
    grant_ifu = ifu_req_valid && !lsu_req_valid;
  end
`endif

  assign accept = ifu_req_ready | lsu_req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = REQ;
      REQ:     if (mem_req_ready) state_nxt = RSP;
      RSP:     if (mem_rsp_valid) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Ready is gated by rst so that no handshake can complete while reset is held.
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        ifu_req_ready = rst & grant_ifu;
        lsu_req_ready = rst & grant_lsu;
      end
      REQ:     mem_req_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_IFU;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (accept) begin
      if (grant_lsu) begin
        owner     <= OWN_LSU;
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wmask <= lsu_wmask;
      end else begin
        owner     <= OWN_IFU;
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
      end
    end
  end

  // Response routing: only a response seen in RSP is delivered; anything else is stray.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rdata     <= '0;
      err           <= 1'b0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      if (mem_rsp_valid) begin
        if (state == RSP) begin
          if (owner == OWN_LSU) begin
            lsu_rsp_valid <= 1'b1;
            lsu_rdata     <= mem_rdata;
          end else begin
            ifu_rsp_valid <= 1'b1;
            ifu_rdata     <= mem_rdata;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, hand-written corner sequences and a randomized scoreboard run for mem_arbiter.
module tb_mem_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [ADDR_W-1:0] ifu_addr;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;
`ifdef MEM_ARB_RR_EN
  bit last_own_lsu = 1'b0;
`endif

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    logic [63:0] ia;
    bit          lv;
    logic [63:0] la;
    bit          lw;
    logic [63:0] ld;
    logic [7:0]  lm;
    int          stall;
    int          delay;
    logic [63:0] rd;
    bit          exp_lsu;
    logic [63:0] exp_addr;
    bit          exp_wen;
    logic [7:0]  exp_wmask;
  } vec_t;

  typedef struct {
    bit          lsu;
    logic [63:0] addr;
    bit          wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } txn_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    next_cycle();
    rst = 1'b1;
`ifdef MEM_ARB_RR_EN
    last_own_lsu = 1'b0;
`endif
  endtask

  task automatic chk_reset(input string p);
    chk($sformatf("%s_ready", p),     64'({ifu_req_ready, lsu_req_ready}), 64'(0));
    chk($sformatf("%s_mem_valid", p), 64'(mem_req_valid), 64'(0));
    chk($sformatf("%s_rsp_valid", p), 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    chk($sformatf("%s_mem_addr", p),  mem_addr, 64'(0));
    chk($sformatf("%s_mem_wdata", p), mem_wdata, 64'(0));
    chk($sformatf("%s_mem_wen_wmask", p), 64'({mem_wen, mem_wmask}), 64'(0));
    chk($sformatf("%s_ifu_rdata", p), ifu_rdata, 64'(0));
    chk($sformatf("%s_lsu_rdata", p), lsu_rdata, 64'(0));
    chk($sformatf("%s_err", p),       64'(err), 64'(0));
  endtask

  task automatic chk_payload(input string p, input vec_t v);
    chk($sformatf("%s_mem_valid", p), 64'(mem_req_valid), 64'(1));
    chk($sformatf("%s_mem_addr", p),  mem_addr, v.exp_addr);
    chk($sformatf("%s_mem_wen", p),   64'(mem_wen), 64'(v.exp_wen));
    chk($sformatf("%s_mem_wmask", p), 64'(mem_wmask), 64'(v.exp_wmask));
    if (v.exp_lsu) chk($sformatf("%s_mem_wdata", p), mem_wdata, v.ld);
    chk($sformatf("%s_ready_busy", p), 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    ifu_req_valid = v.iv; ifu_addr = v.ia;
    lsu_req_valid = v.lv; lsu_addr = v.la; lsu_wen = v.lw; lsu_wdata = v.ld; lsu_wmask = v.lm;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_grant", idx), 64'({ifu_req_ready, lsu_req_ready}),
        64'(v.exp_lsu ? 2'b01 : 2'b10));
    chk($sformatf("v%0d_idle_mem_valid", idx), 64'(mem_req_valid), 64'(0));
    next_cycle();
    // Requesters withdraw and scramble their payload; the latched copy must be unaffected.
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_addr = ~v.ia; lsu_addr = ~v.la; lsu_wen = ~v.lw; lsu_wdata = ~v.ld; lsu_wmask = ~v.lm;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk_payload($sformatf("v%0d_stall%0d", idx, s), v);
      next_cycle();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk_payload($sformatf("v%0d_hs", idx), v);
    next_cycle();
    mem_req_ready = 1'b0;
    for (int d = 0; d < v.delay; d++) begin
      @(negedge clk);
      chk($sformatf("v%0d_wait_mem_valid", idx), 64'(mem_req_valid), 64'(0));
      chk($sformatf("v%0d_wait_rsp", idx), 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
      next_cycle();
    end
    mem_rsp_valid = 1'b1; mem_rdata = v.rd;
    @(negedge clk);
    chk($sformatf("v%0d_pre_rsp", idx), 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    next_cycle();
    mem_rsp_valid = 1'b0; mem_rdata = ~v.rd;
    @(negedge clk);
    chk($sformatf("v%0d_rsp", idx), 64'({ifu_rsp_valid, lsu_rsp_valid}),
        64'(v.exp_lsu ? 2'b01 : 2'b10));
    chk($sformatf("v%0d_rdata", idx), v.exp_lsu ? lsu_rdata : ifu_rdata, v.rd);
    next_cycle();
    @(negedge clk);
    chk($sformatf("v%0d_rsp_pulse_end", idx), 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    chk($sformatf("v%0d_rdata_hold", idx), v.exp_lsu ? lsu_rdata : ifu_rdata, v.rd);
    next_cycle();
  endtask

  // Both requesters held valid; each new grant lands in the same cycle as the previous response.
  task automatic tie_test();
    logic [63:0] a_i, a_l;
    bit          g_lsu, prev_lsu;
    a_i = 64'h0000_0000_8000_0100;
    a_l = 64'h0000_0000_8000_2200;
    prev_lsu = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = a_i;
    lsu_req_valid = 1'b1; lsu_addr = a_l; lsu_wen = 1'b0; lsu_wmask = 8'hFF;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
      g_lsu = (t % 2 == 0);
`else
      g_lsu = 1'b1;
`endif
      @(negedge clk);
      chk($sformatf("tie%0d_grant", t), 64'({ifu_req_ready, lsu_req_ready}),
          64'(g_lsu ? 2'b01 : 2'b10));
      if (t > 0) begin
        chk($sformatf("tie%0d_b2b_rsp", t), 64'({ifu_rsp_valid, lsu_rsp_valid}),
            64'(prev_lsu ? 2'b01 : 2'b10));
        chk($sformatf("tie%0d_b2b_rdata", t), prev_lsu ? lsu_rdata : ifu_rdata, 64'(256 + t - 1));
      end
      next_cycle();
      @(negedge clk);
      chk($sformatf("tie%0d_mem_valid", t), 64'(mem_req_valid), 64'(1));
      chk($sformatf("tie%0d_mem_addr", t), mem_addr, g_lsu ? a_l : a_i);
      next_cycle();
      mem_rsp_valid = 1'b1; mem_rdata = 64'(256 + t);
      @(negedge clk);
      chk($sformatf("tie%0d_rsp_ready", t), 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
      next_cycle();
      mem_rsp_valid = 1'b0;
      prev_lsu = g_lsu;
    end
    @(negedge clk);
    chk("tie_last_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(prev_lsu ? 2'b01 : 2'b10));
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
    next_cycle();
  endtask

  // Randomized traffic checked by a transaction scoreboard built from the arbitration rules.
  task automatic rand_phase(input int ncyc);
    txn_t        q[$];
    txn_t        cur, t;
    bit          iv, lv, busy, pend, mout, rsp_next, rsp_lsu, gi, gl, drv_rsp;
    logic [63:0] rsp_data;
    int          c;
    iv = 0; lv = 0; busy = 0; pend = 0; mout = 0; rsp_next = 0; rsp_lsu = 0;
    rsp_data = '0; cur = '{default: '0};
    for (c = 0; c < ncyc + 200; c++) begin
      if (c >= ncyc && !iv && !lv && !busy && !rsp_next) break;
      if (!iv) begin
        ifu_addr = {$urandom, $urandom};
        if (c < ncyc && $urandom_range(0, 2) == 0) iv = 1'b1;
      end
      if (!lv) begin
        lsu_addr  = {$urandom, $urandom};
        lsu_wen   = 1'($urandom_range(0, 1));
        lsu_wdata = {$urandom, $urandom};
        lsu_wmask = 8'($urandom_range(0, 255));
        if (c < ncyc && $urandom_range(0, 2) == 0) lv = 1'b1;
      end
      ifu_req_valid = iv;
      lsu_req_valid = lv;
      mem_req_ready = ($urandom_range(0, 2) != 0);
      drv_rsp       = mout && ($urandom_range(0, 2) == 0);
      mem_rsp_valid = drv_rsp;
      mem_rdata     = {$urandom, $urandom};
      gi = 1'b0; gl = 1'b0;
      if (!busy) begin
        if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
          gl = !last_own_lsu;
          gi = last_own_lsu;
`else
          gl = 1'b1;
`endif
        end else begin
          gi = iv;
          gl = lv;
        end
      end
      @(negedge clk);
      chk("rnd_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'({gi, gl}));
      chk("rnd_mem_valid", 64'(mem_req_valid), 64'(pend));
      if (pend) begin
        chk("rnd_mem_addr", mem_addr, q[0].addr);
        chk("rnd_mem_wen_wmask", 64'({mem_wen, mem_wmask}), 64'({q[0].wen, q[0].wmask}));
        if (q[0].lsu) chk("rnd_mem_wdata", mem_wdata, q[0].wdata);
      end
      chk("rnd_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}),
          64'({rsp_next && !rsp_lsu, rsp_next && rsp_lsu}));
      if (rsp_next) chk("rnd_rdata", rsp_lsu ? lsu_rdata : ifu_rdata, rsp_data);
      rsp_next = 1'b0;
      if (drv_rsp) begin
        rsp_next = 1'b1; rsp_lsu = cur.lsu; rsp_data = mem_rdata;
        busy = 1'b0; mout = 1'b0;
      end
      if (pend && mem_req_ready) begin
        cur = q.pop_front();
        pend = 1'b0;
        mout = 1'b1;
      end
      if (gi || gl) begin
        t.lsu   = gl;
        t.addr  = gl ? lsu_addr : ifu_addr;
        t.wen   = gl ? lsu_wen : 1'b0;
        t.wdata = lsu_wdata;
        t.wmask = gl ? lsu_wmask : 8'h00;
        q.push_back(t);
        busy = 1'b1; pend = 1'b1;
        if (gl) lv = 1'b0; else iv = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_own_lsu = gl;
`endif
      end
      next_cycle();
    end
    chk("rnd_drained", 64'({iv, lv, busy, rsp_next}), 64'(0));
    chk("rnd_err", 64'(err), 64'(0));
    idle_inputs();
  endtask

  vec_t vecs[5];

  initial begin
    forever begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    vecs[0] = '{1, 64'h8000_0000, 0, 64'h0, 0, 64'h0, 8'h00, 0, 1,
                64'h0000_0013_0000_0093, 0, 64'h8000_0000, 0, 8'h00};
    vecs[1] = '{0, 64'h0, 1, 64'h8000_1000, 1, 64'hDEAD_BEEF, 8'h0F, 3, 0,
                64'h1111_2222_3333_4444, 1, 64'h8000_1000, 1, 8'h0F};
    vecs[2] = '{0, 64'h0, 1, 64'h8000_2008, 0, 64'h5555, 8'hFF, 1, 2,
                64'hCAFE_F00D_1234_5678, 1, 64'h8000_2008, 0, 8'hFF};
    vecs[3] = '{1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h0, 0, 64'h0, 8'h00, 2, 0,
                64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 8'h00};
    vecs[4] = '{0, 64'h0, 1, 64'h0, 1, 64'h0, 8'h80, 0, 0,
                64'h0123_4567_89AB_CDEF, 1, 64'h0, 1, 8'h80};

    rst = 1'b1;
    idle_inputs();
    #2 rst = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    next_cycle();
    idle_inputs();
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    @(negedge clk);
    chk("vec_err", 64'(err), 64'(0));
    next_cycle();

    do_reset();
    tie_test();

    do_reset();
    rand_phase(1500);

    // Stray response in IDLE: sticky err, no pulse, still idle.
    mem_rsp_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    chk("stray_idle_err_before", 64'(err), 64'(0));
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_idle_err", 64'(err), 64'(1));
    chk("stray_idle_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    lsu_req_valid = 1'b1;
    #1;
    chk("stray_idle_still_idle", 64'(lsu_req_ready), 64'(1));
    lsu_req_valid = 1'b0;
    next_cycle();
    repeat (3) begin
      @(negedge clk);
      chk("stray_idle_err_sticky", 64'(err), 64'(1));
      next_cycle();
    end

    // Response in the same cycle as mem_req_ready is stray; the real one still completes.
    do_reset();
    lsu_req_valid = 1'b1; lsu_addr = 64'h40; lsu_wen = 1'b0; lsu_wmask = 8'hFF;
    @(negedge clk);
    chk("stray_req_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'(2'b01));
    next_cycle();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'hAAAA;
    @(negedge clk);
    chk("stray_req_mem_valid", 64'(mem_req_valid), 64'(1));
    next_cycle();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_req_err", 64'(err), 64'(1));
    chk("stray_req_no_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    next_cycle();
    mem_rsp_valid = 1'b1; mem_rdata = 64'h7777_6666_5555_4444;
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_req_real_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(2'b01));
    chk("stray_req_real_rdata", lsu_rdata, 64'h7777_6666_5555_4444);
    next_cycle();

    // Reset while waiting in RSP drops the transaction; the late response is stray.
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
    next_cycle();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    #1;
    chk_reset("mid_rsp");
    next_cycle();
    rst = 1'b1;
    ifu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 64'h0000_0013_0000_0093;
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("mid_rsp_late_err", 64'(err), 64'(1));
    chk("mid_rsp_late_no_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    chk("mid_rsp_late_rdata", ifu_rdata, 64'(0));
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
